// File: rtl/hazard_nop_inserter.sv
// RAW hazard detector between fetch and decode: inserts canonical NOPs until a
// dependent instruction is NOP_GAP slots behind its producer. Define NOP_STATS_EN to build stall_cnt.
module hazard_nop_inserter #(
  parameter int unsigned NOP_GAP = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_instr,
  output logic        out_valid,
  output logic        nop_en,
  output logic [15:0] stall_cnt
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {RUN, STALL} state_t;

  state_t      state;
  logic [4:0]  sb [NOP_GAP];
  logic [31:0] hold;
  logic [4:0]  hold_rd;
  logic [2:0]  nop_left;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd_w;
  logic        use1, use2;
  logic [3:0]  need;
  logic [4:0]  push_rd;
  logic        start_stall, nop_next;

  assign opcode   = in_instr[6:0];
  assign rs1      = in_instr[19:15];
  assign rs2      = in_instr[24:20];
  assign in_ready = (state == RUN);

  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    rd_w = '0;
    case (opcode)
      7'b0110011: begin use1 = 1'b1; use2 = 1'b1; rd_w = in_instr[11:7]; end
      7'b0010011,
      7'b0000011: begin use1 = 1'b1; rd_w = in_instr[11:7]; end
      7'b0100011: begin use1 = 1'b1; use2 = 1'b1; end
      7'b0110111,
      7'b0010111: rd_w = in_instr[11:7];
      default: ;
    endcase
  end

  // Scan oldest to youngest so the youngest matching producer (largest N) wins.
  always_comb begin
    need = '0;
    for (int unsigned i = 0; i < NOP_GAP; i++) begin
      if (sb[NOP_GAP-1-i] != '0 &&
          ((use1 && rs1 == sb[NOP_GAP-1-i]) || (use2 && rs2 == sb[NOP_GAP-1-i])))
        need = 4'(i + 1);
    end
  end

  assign start_stall = (state == RUN) && in_valid && (need != '0);
  assign nop_next    = start_stall || ((state == STALL) && (nop_left != '0));

  always_comb begin
    push_rd = '0;
    if (state == RUN && in_valid && need == '0)
      push_rd = rd_w;
    else if (state == STALL && nop_left == '0)
      push_rd = hold_rd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      out_instr <= NOP;
      out_valid <= 1'b0;
      nop_en    <= 1'b0;
      hold      <= '0;
      hold_rd   <= '0;
      nop_left  <= '0;
      for (int unsigned k = 0; k < NOP_GAP; k++) sb[k] <= '0;
    end else begin
      sb[0] <= push_rd;
      for (int unsigned k = 1; k < NOP_GAP; k++) sb[k] <= sb[k-1];
      case (state)
        RUN: begin
          if (start_stall) begin
            hold      <= in_instr;
            hold_rd   <= rd_w;
            out_instr <= NOP;
            out_valid <= 1'b0;
            nop_en    <= 1'b1;
            nop_left  <= 3'(need - 4'd1);
            state     <= STALL;
          end else if (in_valid) begin
            out_instr <= in_instr;
            out_valid <= 1'b1;
            nop_en    <= 1'b0;
          end else begin
            out_instr <= NOP;
            out_valid <= 1'b0;
            nop_en    <= 1'b0;
          end
        end
        STALL: begin
          if (nop_left != '0) begin
            out_instr <= NOP;
            out_valid <= 1'b0;
            nop_en    <= 1'b1;
            nop_left  <= nop_left - 3'd1;
          end else begin
            out_instr <= hold;
            out_valid <= 1'b1;
            nop_en    <= 1'b0;
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef NOP_STATS_EN
  logic [15:0] cnt;

  // Counted on the edge that raises nop_en, so stall_cnt includes the NOP now on out_instr.
  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (nop_next && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

  assign stall_cnt = cnt;
`else
  logic unused_nop_next;
  assign unused_nop_next = nop_next;
  assign stall_cnt       = '0;
`endif

endmodule
